normalise_prod_iter: RTL

//   Iterative post-multiply normaliser for the HCORDIC float multiply path. Sits between the

---
 rtl/normalise_prod_iter_pkg.sv | 12 +
 rtl/normalise_prod_iter_norm_round_rne.sv | 17 +
 rtl/normalise_prod_iter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/normalise_prod_iter_pkg.sv
// normalise_prod_iter_pkg: shared widths, exponent bound, idle encoding and FSM states
package normalise_prod_iter_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int PROD_W = 50;
  localparam int TAG_W  = 8;
  localparam int E_W    = 10;
  localparam logic signed [E_W-1:0] EMIN = -10'sd126;
  localparam logic no_idle  = 1'b0;
  localparam logic put_idle = 1'b1;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, PASS} state_t;
endpackage

// File: rtl/normalise_prod_iter_norm_round_rne.sv
// norm_round_rne: round-to-nearest-even increment of the mantissa with exponent carry-out
module norm_round_rne
  import normalise_prod_iter_pkg::*;
(
  input  logic [MANT_W-1:0] m_i,
  input  logic              g_i,
  input  logic              r_i,
  input  logic              s_i,
  output logic [MANT_W-1:0] m_o,
  output logic              carry_o
);
  logic [MANT_W:0] sum;
  assign sum = {1'b0, m_i} + (MANT_W+1)'(g_i & (r_i | s_i | m_i[0]));
  assign carry_o = sum[MANT_W];
  // all-ones mantissa overflows to 1.0 with the exponent bumped by the caller
  assign m_o = carry_o ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
endmodule

// File: rtl/normalise_prod_iter.sv
// normalise_prod_iter: iterative one-bit-per-cycle product normaliser with RNE rounding
module normalise_prod_iter
  import normalise_prod_iter_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                idle_Multiply,
  input  logic [32:0]         zout_Multiply,
  input  logic [PROD_W-1:0]   productout_Multiply,
  input  logic [TAG_W-1:0]    InsTagMultiply,
  input  logic                ScaleValidMultiply,
  input  logic [31:0]         z_Multiply,
  output logic                in_ready,
  output logic                idle_NormaliseProd,
  output logic [32:0]         zout_NormaliseProd,
  output logic [PROD_W-1:0]   productout_NormaliseProd,
  output logic [TAG_W-1:0]    InsTagNormaliseProd,
  output logic                ScaleValidNormaliseProd,
  output logic [31:0]         z_NormaliseProd
);
  state_t state_q, state_d;
  logic [MANT_W-1:0] m_q, m_d, m_rnd;
  logic g_q, g_d, r_q, r_d, s_q, s_d, carry;
  logic signed [E_W-1:0] e_q, e_d;
  logic [E_W-1:0] e_rnd;
  logic [32:0] zin_q, zin_d, zout_q, zout_d;
  logic [PROD_W-1:0] prod_q, prod_d, prod_o_q, prod_o_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_o_q, tag_o_d;
  logic [31:0] z_q, z_d, z_o_q, z_o_d;
  logic idle_q, idle_d, idle_o_q, idle_o_d, valid_q, valid_d;

  norm_round_rne u_rne (
    .m_i(m_q), .g_i(g_q), .r_i(r_q), .s_i(s_q), .m_o(m_rnd), .carry_o(carry)
  );
  assign e_rnd = e_q + E_W'(carry);

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    e_d      = e_q;
    zin_d    = zin_q;
    prod_d   = prod_q;
    tag_d    = tag_q;
    z_d      = z_q;
    idle_d   = idle_q;
    zout_d   = zout_q;
    prod_o_d = prod_o_q;
    tag_o_d  = tag_o_q;
    z_o_d    = z_o_q;
    idle_o_d = idle_o_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: if (ScaleValidMultiply) begin
        m_d     = productout_Multiply[PROD_W-1 -: MANT_W];
        g_d     = productout_Multiply[PROD_W-MANT_W-1];
        r_d     = productout_Multiply[PROD_W-MANT_W-2];
        s_d     = |productout_Multiply[PROD_W-MANT_W-3:0];
        e_d     = {{(E_W-EXP_W){zout_Multiply[31]}}, zout_Multiply[31:24]};
        zin_d   = zout_Multiply;
        prod_d  = productout_Multiply;
        tag_d   = InsTagMultiply;
        z_d     = z_Multiply;
        idle_d  = idle_Multiply;
        state_d = idle_Multiply == put_idle ? PASS : NORM;
      end
      NORM: if (e_q < EMIN) begin
        m_d = m_q >> 1;
        g_d = m_q[0];
        r_d = g_q;
        s_d = s_q | r_q;
        e_d = e_q + 10'sd1;
      end else if (!m_q[MANT_W-1] && e_q > EMIN && |{m_q, g_q, r_q}) begin
        m_d = {m_q[MANT_W-2:0], g_q};
        g_d = r_q;
        r_d = 1'b0;
        e_d = e_q - 10'sd1;
      end else begin
        state_d = ROUND;
      end
      default: begin
        // ROUND and PASS both publish the captured side data with a one-cycle pulse
        zout_d   = state_q == ROUND ? {zin_q[32], e_rnd[EXP_W-1:0], m_rnd} : zin_q;
        prod_o_d = prod_q;
        tag_o_d  = tag_q;
        z_o_d    = z_q;
        idle_o_d = idle_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      e_q      <= '0;
      zin_q    <= '0;
      prod_q   <= '0;
      tag_q    <= '0;
      z_q      <= '0;
      idle_q   <= 1'b0;
      zout_q   <= '0;
      prod_o_q <= '0;
      tag_o_q  <= '0;
      z_o_q    <= '0;
      idle_o_q <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      e_q      <= e_d;
      zin_q    <= zin_d;
      prod_q   <= prod_d;
      tag_q    <= tag_d;
      z_q      <= z_d;
      idle_q   <= idle_d;
      zout_q   <= zout_d;
      prod_o_q <= prod_o_d;
      tag_o_q  <= tag_o_d;
      z_o_q    <= z_o_d;
      idle_o_q <= idle_o_d;
      valid_q  <= valid_d;
    end
  end

  assign in_ready                 = state_q == IDLE;
  assign idle_NormaliseProd       = idle_o_q;
  assign zout_NormaliseProd       = zout_q;
  assign productout_NormaliseProd = prod_o_q;
  assign InsTagNormaliseProd      = tag_o_q;
  assign ScaleValidNormaliseProd  = valid_q;
  assign z_NormaliseProd          = z_o_q;
endmodule
